// File: rtl/parity_pkg.sv
// ============================================================================
//  parity_pkg : shared widths, state type and defaults for the parity decoder
//  Revision   : 1.0
// ============================================================================
`default_nettype none

package parity_pkg;

    localparam int DEF_DATA_BITS = 15;
    localparam int FRAME_LEN     = DEF_DATA_BITS + 1;
    localparam int CNT_W         = $clog2(FRAME_LEN);
    localparam int ERRCNT_W      = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_e;

endpackage

`default_nettype wire

// File: rtl/parity_deser.sv
// ============================================================================
//  parity_deser : serial frame capture, running parity and receive FSM;
//                 pulses frame_done_o on the cycle the parity bit is sampled
//  Revision     : 1.0
// ============================================================================
`default_nettype none

module parity_deser
    import parity_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 datain_i,
    input  logic                 datavalid_i,
    input  logic                 resync_i,
    output logic                 frame_done_o,
    output logic [DATA_BITS-1:0] word_o,
    output logic                 perr_o
);

    localparam int              LCL_CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [LCL_CNT_W-1:0] LAST_IDX = LCL_CNT_W'(DATA_BITS);

    state_e                 state_q, state_d;
    logic [LCL_CNT_W-1:0]   count_q, count_d, count_base;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   par_q, par_d, par_base;

    // resync behaves like a return to IDLE seen in the same cycle as the sample
    always_comb begin
        count_base   = (resync_i || state_q == IDLE) ? '0 : count_q;
        par_base     = (resync_i || state_q == IDLE) ? 1'b0 : par_q;
        count_d      = count_base;
        par_d        = par_base;
        data_d       = data_q;
        state_d      = (count_base == '0) ? IDLE : RECV;
        frame_done_o = 1'b0;
        word_o       = data_q;
        perr_o       = par_base ^ datain_i;

        if (datavalid_i) begin
            if (count_base == LAST_IDX) begin
                frame_done_o = 1'b1;
                count_d      = '0;
                par_d        = 1'b0;
                state_d      = IDLE;
            end else begin
                for (int i = 0; i < DATA_BITS; i++) begin
                    if (count_base == LCL_CNT_W'(i)) begin
                        data_d[i] = datain_i;
                    end
                end
                par_d   = par_base ^ datain_i;
                count_d = count_base + 1'b1;
                state_d = RECV;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            data_q  <= data_d;
            par_q   <= par_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/parity_decoder.sv
// ============================================================================
//  parity_decoder : serial parity-checked receiver with a one-entry output
//                   buffer. Optional saturating error counter: PARITY_ERRCNT_EN
//  Revision       : 1.0
// ============================================================================
`default_nettype none

module parity_decoder
    import parity_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 datain,
    input  logic                 datavalid,
    input  logic                 resync,
    output logic [DATA_BITS-1:0] dataout,
    output logic                 outvalid,
    input  logic                 outready,
    output logic                 parityerr,
    output logic                 overrun
`ifdef PARITY_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0]  errcount
`endif
);

    logic                 rx_done;
    logic [DATA_BITS-1:0] rx_word;
    logic                 rx_perr;
    logic                 load;

    logic                 full_q;
    logic [DATA_BITS-1:0] word_q;
    logic                 perr_q;
    logic                 ovr_q;

    parity_deser #(
        .DATA_BITS (DATA_BITS)
    ) u_deser (
        .clk          (clk),
        .rst          (reset),
        .datain_i     (datain),
        .datavalid_i  (datavalid),
        .resync_i     (resync),
        .frame_done_o (rx_done),
        .word_o       (rx_word),
        .perr_o       (rx_perr)
    );

    // an accept in the completion cycle frees the slot for the new word
    assign load = rx_done && (!full_q || outready);

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 1'b0;
            word_q <= '0;
            perr_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            if (load) begin
                word_q <= rx_word;
                perr_q <= rx_perr;
                full_q <= 1'b1;
            end else if (rx_done) begin
                ovr_q  <= 1'b1;
            end else if (outready) begin
                full_q <= 1'b0;
            end
        end
    end

    assign dataout   = word_q;
    assign parityerr = perr_q;
    assign outvalid  = full_q;
    assign overrun   = ovr_q;

`ifdef PARITY_ERRCNT_EN
    logic [ERRCNT_W-1:0] errcnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            errcnt_q <= '0;
        end else if (load && rx_perr && (errcnt_q != '1)) begin
            errcnt_q <= errcnt_q + 1'b1;
        end
    end

    assign errcount = errcnt_q;
`else
    // error counter not built in this configuration
`endif

endmodule

`default_nettype wire

// File: tb/tb_parity_decoder.sv
// ============================================================================
//  tb_parity_decoder : directed + randomized bench with a frame-level model
//  Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_parity_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, datain, datavalid, resync, outready;
    logic [14:0] dataout;
    logic        outvalid, parityerr, overrun;
`ifdef PARITY_ERRCNT_EN
    logic [7:0]  errcount;
`endif

    int vectors     = 0;
    int miscompares = 0;

    parity_decoder dut (
        .clk       (clk),
        .reset     (reset),
        .datain    (datain),
        .datavalid (datavalid),
        .resync    (resync),
        .dataout   (dataout),
        .outvalid  (outvalid),
        .outready  (outready),
        .parityerr (parityerr),
        .overrun   (overrun)
`ifdef PARITY_ERRCNT_EN
        ,
        .errcount  (errcount)
`endif
    );

    // frame-level model: a list of sampled bits, turned into a word at 16
    bit          fbits[$];
    bit          m_full, m_err, m_ovr;
    logic [14:0] m_word;
    int          m_cnt;
    bit          chk_en = 1'b0;
    int          rises  = 0;
    logic        prev_ov = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit          done;
        logic [14:0] w;
        int          ones;
        done = 1'b0;
        w    = '0;
        ones = 0;
        if (reset) begin
            fbits.delete();
            m_full = 1'b0; m_err = 1'b0; m_ovr = 1'b0; m_word = '0; m_cnt = 0;
        end else begin
            if (resync) fbits.delete();
            if (datavalid) begin
                fbits.push_back(datain);
                if (fbits.size() == 16) begin
                    done = 1'b1;
                    for (int i = 0; i < 16; i++) begin
                        if (i < 15) w[i] = fbits[i];
                        ones += int'(fbits[i]);
                    end
                    fbits.delete();
                end
            end
            if (done) begin
                if (!m_full || outready) begin
                    m_word = w;
                    m_err  = (ones % 2) == 1;
                    m_full = 1'b1;
                    if (m_err && m_cnt < 255) m_cnt++;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (outready) begin
                m_full = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("outvalid",  {31'd0, outvalid},  {31'd0, m_full});
            chk("dataout",   {17'd0, dataout},   {17'd0, m_word});
            chk("parityerr", {31'd0, parityerr}, {31'd0, m_err});
            chk("overrun",   {31'd0, overrun},   {31'd0, m_ovr});
`ifdef PARITY_ERRCNT_EN
            chk("errcount",  {24'd0, errcount},  m_cnt);
`endif
            if (outvalid && !prev_ov) rises++;
            prev_ov = outvalid;
        end
    end

    task automatic drive(input logic r, input logic dv, input logic d,
                         input logic rs, input logic rdy);
        reset = r; datavalid = dv; datain = d; resync = rs; outready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [14:0] w, input logic p, input int gap,
                              input logic rdy);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, (i < 15) ? w[i] : p, 1'b0, rdy);
            if (i < 15) begin
                for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 1'($urandom), 1'b0, rdy);
            end
        end
    endtask

    initial begin
        logic [14:0] rw;
        reset = 1'b1; datavalid = 1'b0; datain = 1'b0; resync = 1'b0; outready = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_outvalid", {31'd0, outvalid}, 32'd0);
        chk("rst_dataout",  {17'd0, dataout},  32'd0);
        chk("rst_overrun",  {31'd0, overrun},  32'd0);

        send_frame(15'h0001, 1'b1, 0, 1'b1);
        chk("f1_outvalid", {31'd0, outvalid},  32'd1);
        chk("f1_dataout",  {17'd0, dataout},   32'h0001);
        chk("f1_perr",     {31'd0, parityerr}, 32'd0);

        send_frame(15'h0001, 1'b0, 0, 1'b1);
        chk("f2_dataout",  {17'd0, dataout},   32'h0001);
        chk("f2_perr",     {31'd0, parityerr}, 32'd1);
`ifdef PARITY_ERRCNT_EN
        chk("f2_errcount", {24'd0, errcount},  32'd1);
`endif

        send_frame(15'h7FFF, 1'b1, 3, 1'b1);
        chk("gap_dataout", {17'd0, dataout},   32'h7FFF);
        chk("gap_perr",    {31'd0, parityerr}, 32'd0);

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(15'h1234, 1'b1, 0, 1'b0);
        chk("hold_outvalid", {31'd0, outvalid}, 32'd1);
        chk("hold_dataout",  {17'd0, dataout},  32'h1234);
        send_frame(15'h5555, 1'b0, 0, 1'b0);
        chk("ovr_overrun",   {31'd0, overrun},  32'd1);
        chk("ovr_dataout",   {17'd0, dataout},  32'h1234);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_drained",   {31'd0, outvalid}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        rises = 0;
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 1'($urandom), 1'b0, 1'b1);
        rw = 15'h2A5A;
        drive(1'b0, 1'b1, rw[0], 1'b1, 1'b1);
        for (int i = 1; i < 16; i++) drive(1'b0, 1'b1, (i < 15) ? rw[i] : 1'b1, 1'b0, 1'b1);
        chk("rsy_dataout", {17'd0, dataout},   32'h2A5A);
        chk("rsy_perr",    {31'd0, parityerr}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rsy_words",   rises, 32'd1);

        for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 1'($urandom), 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'($urandom), 1'b0, 1'b1);
        chk("mrst_outvalid", {31'd0, outvalid},  32'd0);
        chk("mrst_dataout",  {17'd0, dataout},   32'd0);
        chk("mrst_perr",     {31'd0, parityerr}, 32'd0);
        chk("mrst_overrun",  {31'd0, overrun},   32'd0);
        send_frame(15'h0F0F, 1'b0, 0, 1'b1);
        chk("mrst_frame",    {17'd0, dataout},   32'h0F0F);
        chk("mrst_fperr",    {31'd0, parityerr}, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 300) == 0, ($urandom % 10) < 7, 1'($urandom),
                  ($urandom % 50) == 0, ($urandom % 10) < 6);
        end
        for (int i = 0; i < 64; i++) drive(1'b0, 1'b1, 1'($urandom), 1'b0, 1'b1);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
